button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input-conditioning stage between the raw board push-buttons and the game logic. It synchronises each button to `clk`, debounces it, and produces a clean pressed level. It also produces a stretched press event wide enough for the divided-clock `state_machine` and the `button_handler` remap to see reliably. Optional auto-repeat turns a held direction button into repeated events for cursor movement.

## Interface
- `NUM_BUTTONS`, 7: number of buttons. Bit map: 0 a, 1 b, 2 up, 3 down, 4 left, 5 right, 6 start.
- `ACTIVE_LOW`, 1: 1 means raw pins read 0 when pressed (board keys); 0 means active-high.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a new level must persist (20 ms at 50 MHz). Must be ≥ 2.
- `PULSE_CYCLES`, 6_250_000: width of each press event. Equals one game-clock period. Must be ≥ 1.
- `REPEAT_DELAY`, 25_000_000: hold time before the first auto-repeat event.
- `REPEAT_PERIOD`, 12_500_000: interval between subsequent auto-repeat events.
- `REPEAT_MASK`, 7'b0111100: buttons eligible for auto-repeat (directions only).
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `raw_buttons`  in  NUM_BUTTONS  unsynchronised pin levels.
- `stable_buttons`  out  NUM_BUTTONS  debounced level, 1 = pressed.
- `press_pulse`  out  NUM_BUTTONS  stretched press event, 1 = event active.
- `any_pressed`  out  1  OR of `stable_buttons`.

## Operation
- Per button, the stages are:
  - two-flop synchroniser;
  - polarity normalisation to pressed = 1;
  - debounce counter;
  - stable register;
  - stretch counter;
  - repeat counter (only when configured).
- Debounce:
  - If the synchronised level equals `stable`, the counter is set to 0.
  - If the level differs and counter < DEBOUNCE_CYCLES−1, the counter increments.
  - If the level differs and counter == DEBOUNCE_CYCLES−1, `stable` takes the new level and the counter is set to 0.
  - Any bounce back to the `stable` level restarts the count from 0.
- Press event:
  - A 0→1 transition of `stable` loads the stretch counter with PULSE_CYCLES.
  - `press_pulse` = (stretch counter ≠ 0). The counter decrements each cycle down to 0.
  - A new event (press or repeat) while the counter is nonzero reloads it to PULSE_CYCLES, extending the pulse. Overlapping events are not counted.
  - Release (1→0) generates no event and does not shorten an active pulse.
- Width rules: each counter is `$clog2(limit+1)` bits wide. Counters saturate and never wrap.
- Buttons are fully independent. Simultaneous presses on several bits each produce their own event in the same cycle.
- Reset (asserted at any time, including mid-count or mid-pulse):
  - all outputs go to 0;
  - synchroniser flops take the unpressed raw level;
  - all counters clear.
  - After release, a button already held low counts as a new press after the full debounce latency.

## Timing
- Edge 1 is the first `clk` edge that samples a new raw level.
  - The synchroniser output changes at edge 2.
  - `stable_buttons` and `press_pulse` rise together at edge DEBOUNCE_CYCLES+2.
- `press_pulse` stays high for exactly PULSE_CYCLES cycles after a single event.
- `any_pressed` is registered and updates on the same edge as `stable_buttons`.
- Release: `stable` falls at edge DEBOUNCE_CYCLES+2 after the release edge. The repeat counter clears on that same edge.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no output change.

## Configuration
- `BUTTON_REPEAT_EN` defined:
  - For bits set in REPEAT_MASK, a repeat counter runs while `stable` = 1.
  - The first repeat event fires REPEAT_DELAY cycles after `stable` rose.
  - Further events fire every REPEAT_PERIOD cycles while the button is held.
  - Each repeat event reloads the stretch counter, exactly like a press.
  - The counter clears when `stable` = 0.
- `BUTTON_REPEAT_EN` undefined:
  - No repeat counters are built, and the REPEAT_* parameters are ignored.
  - One event per press, regardless of hold time.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, REPEAT_DELAY=10, REPEAT_PERIOD=5, ACTIVE_LOW=1.

- Reset held low with all raw bits 0 (all pressed) → all outputs 0. After release, all bits `stable` = 1 at edge 6 and `press_pulse` = 7'h7F for 3 cycles.
- raw bit 0 goes low cleanly at edge 1 → `stable_buttons[0]` = 1 and `press_pulse[0]` = 1 at edge 6, with `press_pulse[0]` low again at edge 9.
- raw bit 2 toggles low/high every 2 cycles for 20 cycles, then stays high → no change on any output.
- Bit 3 held pressed 30 cycles with the macro defined → `press_pulse[3]` rises at cycles 0, 10, 15, 20, 25 relative to the press event. Without the macro → rises once.
- Bit 6 (start, not in REPEAT_MASK) held 30 cycles with the macro defined → exactly one 3-cycle pulse.
- Reset asserted mid-pulse on bit 1 → `press_pulse[1]` = 0 immediately (asynchronous), and no residual pulse after reset release with the raw level unpressed.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Input conditioning between raw board push-buttons and the game logic.
// Each button is synchronised to clk, polarity-normalised (1 = pressed),
// debounced into a stable level, and turned into a stretched press event
// wide enough for slower divided-clock consumers to sample reliably.
//
// Optional feature (compile-time macro BUTTON_REPEAT_EN):
//   held buttons selected by REPEAT_MASK generate auto-repeat events, first
//   after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous reset, active low
//   raw_buttons    in   unsynchronised pin levels (polarity per ACTIVE_LOW)
//   stable_buttons out  debounced level, 1 = pressed
//   press_pulse    out  stretched press/repeat event, 1 = active
//   any_pressed    out  registered OR of stable_buttons
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int unsigned             NUM_BUTTONS     = 7,
    parameter bit                      ACTIVE_LOW      = 1'b1,
    parameter int unsigned             DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned             PULSE_CYCLES    = 6_250_000,
    parameter int unsigned             REPEAT_DELAY    = 25_000_000,
    parameter int unsigned             REPEAT_PERIOD   = 12_500_000,
    parameter logic [NUM_BUTTONS-1:0]  REPEAT_MASK     = 7'b0111100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] raw_buttons,
    output logic [NUM_BUTTONS-1:0] stable_buttons,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic                   any_pressed
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW   = $clog2(PULSE_CYCLES + 1);

    localparam logic [DB_W-1:0]        DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]          PULSE_LOAD = PW'(PULSE_CYCLES);
    localparam logic [NUM_BUTTONS-1:0] RAW_IDLE   = {NUM_BUTTONS{ACTIVE_LOW}};

    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] stable_q, stable_d;
    logic                   any_q, any_d;
    logic [NUM_BUTTONS-1:0] rise;
    logic [NUM_BUTTONS-1:0] rpt_fire;
    logic [NUM_BUTTONS-1:0] press_event;
    logic [DB_W-1:0]        db_cnt_q  [NUM_BUTTONS];
    logic [DB_W-1:0]        db_cnt_d  [NUM_BUTTONS];
    logic [PW-1:0]          str_cnt_q [NUM_BUTTONS];
    logic [PW-1:0]          str_cnt_d [NUM_BUTTONS];

    assign level = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Debounce: the count only advances while the level disagrees with stable;
    // agreement (including a bounce back) restarts it from zero.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            db_cnt_d[i] = '0;
            if (level[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = level[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        rise  = stable_d & ~stable_q;
        any_d = |stable_d;
    end

`ifdef BUTTON_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] RPT_DELAY_LD  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PERIOD_LD = RW'(REPEAT_PERIOD);

    logic [RW-1:0] rpt_cnt_q [NUM_BUTTONS];
    logic [RW-1:0] rpt_cnt_d [NUM_BUTTONS];

    // Down-counter loaded on the press edge; reaching 1 fires an event and
    // reloads with the period. It clears on the edge where stable falls.
    always_comb begin
        rpt_fire = '0;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            rpt_cnt_d[i] = '0;
            if (REPEAT_MASK[i] && stable_d[i]) begin
                if (!stable_q[i]) begin
                    rpt_cnt_d[i] = RPT_DELAY_LD;
                end else if (rpt_cnt_q[i] == RW'(1)) begin
                    rpt_fire[i]  = 1'b1;
                    rpt_cnt_d[i] = RPT_PERIOD_LD;
                end else if (rpt_cnt_q[i] != '0) begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] - RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) rpt_cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_MASK, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rpt_fire          = '0;
`endif

    // Stretch: any event (re)loads the full width; otherwise count down to 0.
    always_comb begin
        press_event = rise | rpt_fire;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            if (press_event[i]) begin
                str_cnt_d[i] = PULSE_LOAD;
            end else if (str_cnt_q[i] != '0) begin
                str_cnt_d[i] = str_cnt_q[i] - PW'(1);
            end else begin
                str_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= RAW_IDLE;
            sync2_q  <= RAW_IDLE;
            stable_q <= '0;
            any_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt_q[i]  <= '0;
                str_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= raw_buttons;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            any_q    <= any_d;
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                str_cnt_q[i] <= str_cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            press_pulse[i] = (str_cnt_q[i] != '0);
        end
    end

    assign stable_buttons = stable_q;
    assign any_pressed    = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner with small timing parameters.
// A timestamp-based reference model predicts stable level, press pulse and
// any_pressed every cycle; directed scenarios plus a randomized phase drive it.
// Honours BUTTON_REPEAT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int NB   = 7;
    localparam int DB   = 4;
    localparam int PC   = 3;
    localparam int RDLY = 10;
    localparam int RPER = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] raw_buttons;
    logic [NB-1:0] stable_buttons;
    logic [NB-1:0] press_pulse;
    logic          any_pressed;

    button_conditioner #(
        .NUM_BUTTONS    (NB),
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(DB),
        .PULSE_CYCLES   (PC),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER),
        .REPEAT_MASK    (7'b0111100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .raw_buttons   (raw_buttons),
        .stable_buttons(stable_buttons),
        .press_pulse   (press_pulse),
        .any_pressed   (any_pressed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // ---------------- reference model (timestamps, not counters) -------------
    logic [NB-1:0] rmask = 7'b0111100;
    int   n;                       // edge number
    bit   m_s1    [NB];            // pressed level in first sync stage
    bit   m_lvl   [NB];            // pressed level out of the synchroniser
    int   m_since [NB];            // edge at which m_lvl took its value
    bit   m_stab  [NB];
    int   m_rise  [NB];            // edge at which stable rose
    int   m_last  [NB];            // edge of most recent press event

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            m_s1[b] = 0; m_lvl[b] = 0; m_since[b] = n;
            m_stab[b] = 0; m_rise[b] = -1000; m_last[b] = -1000;
        end
    endfunction

    function automatic void model_step(input logic [NB-1:0] raw);
        bit new_s, ev;
        n++;
        for (int b = 0; b < NB; b++) begin
            new_s = m_stab[b];
            ev    = 0;
            if (m_lvl[b] != m_stab[b] && (n - m_since[b]) >= DB) new_s = m_lvl[b];
            if (new_s && !m_stab[b]) begin
                m_rise[b] = n;
                ev = 1;
            end
`ifdef BUTTON_REPEAT_EN
            if (rmask[b] && new_s && m_stab[b] && (n - m_rise[b]) >= RDLY &&
                ((n - m_rise[b] - RDLY) % RPER) == 0) ev = 1;
`endif
            m_stab[b] = new_s;
            if (ev) m_last[b] = n;
            if (m_s1[b] != m_lvl[b]) m_since[b] = n;
            m_lvl[b] = m_s1[b];
            m_s1[b]  = !raw[b];
        end
    endfunction

    function automatic logic [NB-1:0] exp_stable();
        logic [NB-1:0] v;
        for (int b = 0; b < NB; b++) v[b] = m_stab[b];
        return v;
    endfunction

    function automatic logic [NB-1:0] exp_pulse();
        logic [NB-1:0] v;
        for (int b = 0; b < NB; b++) v[b] = (n - m_last[b]) < PC;
        return v;
    endfunction

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        logic [NB-1:0] es;
        @(posedge clk);
        if (reset) model_step(raw_buttons);
        else begin
            n++;
            model_reset();
        end
        @(negedge clk);
        es = exp_stable();
        check_eq("stable", 32'(stable_buttons), 32'(es));
        check_eq("pulse",  32'(press_pulse),    32'(exp_pulse()));
        check_eq("any",    32'(any_pressed),    32'(|es));
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // Hold one button, then count pulse rises and high cycles over 30 cycles.
    task automatic hold_and_count(input int b, input int exp_rises, input int exp_high, input string tag);
        int rises, high, waited;
        logic prev;
        raw_buttons[b] = 1'b0;
        waited = 0;
        while (!press_pulse[b] && waited < 20) begin
            tick();
            waited++;
        end
        if (!press_pulse[b]) begin
            check_eq({tag, "_timeout"}, 32'(press_pulse[b]), 32'd1);
        end else begin
            rises = 1; high = 1; prev = 1'b1;
            for (int i = 1; i < 30; i++) begin
                tick();
                if (press_pulse[b] && !prev) rises++;
                if (press_pulse[b]) high++;
                prev = press_pulse[b];
            end
            check_eq({tag, "_rises"}, 32'(rises), 32'(exp_rises));
            check_eq({tag, "_high"},  32'(high),  32'(exp_high));
        end
        raw_buttons[b] = 1'b1;
        ticks(15);
    endtask

    int seg_left [NB];

    initial begin
        n = 0;
        model_reset();
        reset       = 1'b0;
        raw_buttons = '0;             // all pressed while in reset
        ticks(3);
        reset = 1'b1;
        ticks(12);                    // all bits debounce in together

        raw_buttons = '1;
        ticks(15);

        // clean press on bit 0
        raw_buttons[0] = 1'b0;
        ticks(12);
        raw_buttons[0] = 1'b1;
        ticks(12);

        // bit 2 bouncing with 2-cycle segments: never long enough to register
        for (int i = 0; i < 10; i++) begin
            raw_buttons[2] = i[0];
            ticks(2);
        end
        raw_buttons[2] = 1'b1;
        ticks(12);

`ifdef BUTTON_REPEAT_EN
        hold_and_count(3, 5, 5 * PC, "b3_hold");
`else
        hold_and_count(3, 1, PC, "b3_hold");
`endif
        hold_and_count(6, 1, PC, "b6_hold");

        // reset asserted mid-pulse on bit 1
        raw_buttons[1] = 1'b0;
        for (int i = 0; i < 20 && !press_pulse[1]; i++) tick();
        check_eq("b1_pulse_seen", 32'(press_pulse[1]), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        check_eq("async_rst_pulse",  32'(press_pulse),    32'd0);
        check_eq("async_rst_stable", 32'(stable_buttons), 32'd0);
        check_eq("async_rst_any",    32'(any_pressed),    32'd0);
        model_reset();
        raw_buttons[1] = 1'b1;
        ticks(2);
        reset = 1'b1;
        ticks(15);

        // randomized segments: mix of bounces and long holds, occasional reset
        for (int b = 0; b < NB; b++) seg_left[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NB; b++) begin
                if (seg_left[b] == 0) begin
                    raw_buttons[b] = 1'($urandom_range(0, 1));
                    seg_left[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                              : int'($urandom_range(5, 40));
                end
                seg_left[b]--;
            end
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                #1;
                check_eq("rand_rst_pulse", 32'(press_pulse), 32'd0);
                model_reset();
                ticks(int'($urandom_range(1, 3)));
                reset = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
